mc_ctrl: RTL and testbench
==========================

# mc_ctrl

Multi-cycle control sequencer for the CPU datapath. It replaces the purely combinational single-cycle decode with a Moore FSM. The FSM:
- steps each instruction through fetch, decode, execute, memory and write-back;
- drives the PC, IR, register-file, memory and ALU mux/enable strobes;
- stalls on a shared instruction/data memory port via a ready handshake.

It sits beside the PC/GPR/ALU datapath and is the only source of its write enables.

## Interface
Parameters:
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `op`  in  6  opcode, taken from the IR (stable after FETCH).
- `funct`  in  6  function field, taken from the IR.
- `mem_ready`  in  1  memory port has completed the current access this cycle.
- `pc_write`  out  1  unconditional PC load.
- `pc_write_cond`  out  1  PC load if ALU `zero` (the datapath ANDs these).
- `ir_write`  out  1  latch instruction into IR.
- `mem_read`  out  1  memory read request.
- `mem_write`  out  1  memory write request.
- `i_or_d`  out  1  memory address select: 0=PC, 1=ALU out.
- `alu_src_a`  out  1  select: 0=PC, 1=rs.
- `alu_src_b`  out  2  select: 0=rt, 1=const 4, 2=ext imm, 3=ext imm<<2.
- `if_extend`  out  1  select: 1=sign-extend, 0=zero-extend.
- `aluop`  out  5  ALU operation code.
- `reg_write`  out  1  GPR write enable.
- `reg_dst`  out  1  destination select: 0=rt, 1=rd.
- `mem_to_reg`  out  1  write-back data select: 0=ALU out, 1=memory data.
- `pc_src`  out  2  next-PC select: 0=ALU, 1=ALU out register, 2=jump target.
- `illegal_op`  out  1  one-cycle pulse in DECODE for an unsupported opcode.
- `retired`  out  CNT_W  count of completed instructions.

## Operation
States:
- FETCH
- DECODE
- EXEC_R
- EXEC_I
- MEM_ADDR
- MEM_RD
- MEM_WB
- MEM_WR
- ALU_WB
- BRANCH
- JUMP

Supported opcodes:
- R-type 000000
- addi 001000
- ori 001101
- lw 100011
- sw 101011
- beq 000100
- j 000010

FETCH:
- Asserts `mem_read`, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=1, `aluop`=ADD, `pc_src`=0.
- Asserts `ir_write` and `pc_write` only in the cycle `mem_ready`=1. That cycle goes to DECODE; otherwise the FSM holds in FETCH.

DECODE:
- Computes the branch target: `alu_src_a`=0, `alu_src_b`=3, `if_extend`=1, `aluop`=ADD.
- Transitions by `op`:
  - R-type → EXEC_R
  - addi/ori → EXEC_I
  - lw/sw → MEM_ADDR
  - beq → BRANCH
  - j → JUMP
  - any other opcode → FETCH, with `illegal_op` pulsed. The instruction is not counted.

Execute and memory states:
- EXEC_R: `alu_src_a`=1, `alu_src_b`=0; `aluop` is decoded from `funct`. Goes to ALU_WB.
- EXEC_I: `alu_src_a`=1, `alu_src_b`=2. For addi: `if_extend`=1, `aluop`=ADD. For ori: `if_extend`=0, `aluop`=OR. Goes to ALU_WB.
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=2, `if_extend`=1, `aluop`=ADD. Goes to MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: `mem_read`, `i_or_d`=1. Holds until `mem_ready`, then goes to MEM_WB.

Write-back and completion states (each returns to FETCH):
- MEM_WB: `reg_write`, `reg_dst`=0, `mem_to_reg`=1.
- MEM_WR: `mem_write`, `i_or_d`=1. Holds until `mem_ready`, then goes to FETCH.
- ALU_WB: `reg_write`, `mem_to_reg`=0. `reg_dst`=1 for R-type, 0 for I-type.
- BRANCH: `alu_src_a`=1, `alu_src_b`=0, `aluop`=SUB, `pc_write_cond`, `pc_src`=1.
- JUMP: `pc_write`, `pc_src`=2.

funct decode to `aluop`:
- add 100000 → ADD
- sub 100010 → SUB
- and 100100 → AND
- or 100101 → OR
- slt 101010 → SLT
- Any other funct → ADD, with `illegal_op` pulsed in EXEC_R. The instruction still writes back.

Default value:
- Every output not listed for a state is 0 in that state.
- `aluop` defaults to ADD.

`retired`:
- Increments by 1 on the clock edge leaving MEM_WB, ALU_WB, BRANCH, JUMP, or MEM_WR (MEM_WR counts only when `mem_ready`=1).
- Wraps modulo 2^CNT_W.

## Timing
- Outputs are Moore: decoded from the state register plus the held `op`/`funct`. None depend combinationally on `mem_ready`, except `pc_write`/`ir_write` in FETCH.
- Cycle counts with zero wait:
  - beq and j: 3 cycles.
  - R-type, addi, ori and sw: 4 cycles.
  - lw: 5 cycles.
  - Each cycle of `mem_ready`=0 in FETCH, MEM_RD or MEM_WR adds one cycle.
- Reset asserted (`reset`=0), effective immediately and asynchronously:
  - State becomes FETCH and `retired` becomes 0.
  - All enables (`pc_write`, `pc_write_cond`, `ir_write`, `mem_read`, `mem_write`, `reg_write`) are forced to 0 while reset is held.
  - Remaining outputs are 0; `aluop` is ADD.
- Reset mid-access: any pending MEM_RD/MEM_WR request is dropped in the same cycle and no write-back occurs.
- First FETCH request is raised in the first cycle after `reset` returns high.
- `mem_ready` high outside FETCH/MEM_RD/MEM_WR is ignored.

## Structure
- Package `cpu_pkg`:
  - opcode and funct constants;
  - the 5-bit `aluop` codes: ADD=0, SUB=1, AND=2, OR=3, SLT=4;
  - `alu_src_b` and `pc_src` select encodings;
  - the state enum.
- Sub-module `alu_dec`: combinational funct→`aluop` plus an illegal-funct flag. It is shared with the single-cycle control path.
- The FSM, output decode and `retired` counter live in `mc_ctrl`.

## Test plan
- Reset then an R-type add (op=0, funct=100000), `mem_ready`=1: state sequence FETCH, DECODE, EXEC_R, ALU_WB. `reg_write`=1 and `reg_dst`=1 in cycle 4; `retired`=1.
- lw (op=100011) with `mem_ready` low for 2 cycles in MEM_RD: 7 cycles total. `mem_read` and `i_or_d` are held high throughout MEM_RD; `mem_to_reg`=1 in MEM_WB.
- sw (op=101011) then beq (op=000100): `mem_write` asserted exactly until `mem_ready`, and `reg_write` never asserted. BRANCH asserts `pc_write_cond`=1, `pc_src`=1, `aluop`=SUB; `retired`=2.
- op=111111: `illegal_op` pulses for one cycle in DECODE, then FETCH next; `retired` unchanged. funct=000111 in an R-type pulses `illegal_op` in EXEC_R.
- `reset` driven low mid-cycle during MEM_WR: outputs go to zero with no clock edge; after release the FSM is in FETCH with `retired`=0.
- CNT_W=4: retire 17 instructions; `retired` ends at 1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU control path: opcode/funct constants,
// ALU operation codes, datapath mux encodings and the multi-cycle state enum.
package cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [4:0] ALU_ADD = 5'd0;
    localparam logic [4:0] ALU_SUB = 5'd1;
    localparam logic [4:0] ALU_AND = 5'd2;
    localparam logic [4:0] ALU_OR  = 5'd3;
    localparam logic [4:0] ALU_SLT = 5'd4;

    localparam logic [1:0] SRCB_RT      = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    typedef enum logic [3:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC_R,
        ST_EXEC_I,
        ST_MEM_ADDR,
        ST_MEM_RD,
        ST_MEM_WB,
        ST_MEM_WR,
        ST_ALU_WB,
        ST_BRANCH,
        ST_JUMP
    } state_e;

endpackage

// File: rtl/alu_dec.sv
// Combinational R-type function decoder: funct -> ALU operation code.
// Unknown funct values fall back to ADD and raise illegal.
// Ports: funct (6b in), aluop (5b out), illegal (1b out).
module alu_dec
    import cpu_pkg::*;
(
    input  logic [5:0] funct,
    output logic [4:0] aluop,
    output logic       illegal
);

    always_comb begin
        aluop   = ALU_ADD;
        illegal = 1'b0;
        case (funct)
            FN_ADD:  aluop = ALU_ADD;
            FN_SUB:  aluop = ALU_SUB;
            FN_AND:  aluop = ALU_AND;
            FN_OR:   aluop = ALU_OR;
            FN_SLT:  aluop = ALU_SLT;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle Moore control sequencer for the CPU datapath.
// Inputs : clock, reset (async, active-low), op, funct, mem_ready.
// Outputs: PC/IR/GPR/memory strobes, ALU and mux selects, illegal_op pulse,
//          retired-instruction counter (CNT_W bits, wraps).
//
// state     | meaning
// ----------+-----------------------------------------------
// FETCH     | read instruction at PC, PC+4; wait mem_ready
// DECODE    | branch target into ALU out, dispatch on op
// EXEC_R    | rs (funct) rt
// EXEC_I    | rs (add/or) extended immediate
// MEM_ADDR  | rs + sign-extended immediate
// MEM_RD    | data read at ALU out; wait mem_ready
// MEM_WB    | memory data -> rt
// MEM_WR    | data write at ALU out; wait mem_ready
// ALU_WB    | ALU out -> rd (R-type) or rt (I-type)
// BRANCH    | rs - rt, conditional PC load from ALU out
// JUMP      | PC load from jump target
module mc_ctrl
    import cpu_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             ir_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             i_or_d,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             if_extend,
    output logic [4:0]       aluop,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic [1:0]       pc_src,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q;
    logic [4:0]       r_aluop;
    logic             r_illegal;
    logic             retire;

    alu_dec u_alu_dec (
        .funct   (funct),
        .aluop   (r_aluop),
        .illegal (r_illegal)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_FETCH;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign retire = (state_q == ST_MEM_WB) || (state_q == ST_ALU_WB) ||
                    (state_q == ST_BRANCH) || (state_q == ST_JUMP) ||
                    ((state_q == ST_MEM_WR) && mem_ready);
    assign retired = retired_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH:    if (mem_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                case (op)
                    OP_RTYPE:        state_d = ST_EXEC_R;
                    OP_ADDI, OP_ORI: state_d = ST_EXEC_I;
                    OP_LW, OP_SW:    state_d = ST_MEM_ADDR;
                    OP_BEQ:          state_d = ST_BRANCH;
                    OP_J:            state_d = ST_JUMP;
                    default:         state_d = ST_FETCH;
                endcase
            end
            ST_EXEC_R:   state_d = ST_ALU_WB;
            ST_EXEC_I:   state_d = ST_ALU_WB;
            ST_MEM_ADDR: state_d = (op == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD:   if (mem_ready) state_d = ST_MEM_WB;
            ST_MEM_WR:   if (mem_ready) state_d = ST_FETCH;
            default:     state_d = ST_FETCH;
        endcase
    end

    // Outputs are gated by reset so every strobe drops the instant reset is
    // asserted, even though the state register already reads FETCH.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        i_or_d        = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_RT;
        if_extend     = 1'b0;
        aluop         = ALU_ADD;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        pc_src        = PCSRC_ALU;
        illegal_op    = 1'b0;
        if (reset) begin
            case (state_q)
                ST_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                ST_DECODE: begin
                    alu_src_b = SRCB_IMM_SH2;
                    if_extend = 1'b1;
                    case (op)
                        OP_RTYPE, OP_ADDI, OP_ORI, OP_LW,
                        OP_SW, OP_BEQ, OP_J: illegal_op = 1'b0;
                        default:             illegal_op = 1'b1;
                    endcase
                end
                ST_EXEC_R: begin
                    alu_src_a  = 1'b1;
                    aluop      = r_aluop;
                    illegal_op = r_illegal;
                end
                ST_EXEC_I: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    if_extend = (op != OP_ORI);
                    aluop     = (op == OP_ORI) ? ALU_OR : ALU_ADD;
                end
                ST_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    if_extend = 1'b1;
                end
                ST_MEM_RD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                ST_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                ST_MEM_WR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                ST_ALU_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = (op == OP_RTYPE);
                end
                ST_BRANCH: begin
                    alu_src_a     = 1'b1;
                    aluop         = ALU_SUB;
                    pc_write_cond = 1'b1;
                    pc_src        = PCSRC_ALUOUT;
                end
                ST_JUMP: begin
                    pc_write = 1'b1;
                    pc_src   = PCSRC_JUMP;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed instructions, then randomized
// instruction/wait streams checked against a per-instruction summary model.
module tb_mc_ctrl;

    localparam logic [5:0] T_R = 6'b000000, T_ADDI = 6'b001000, T_ORI = 6'b001101,
                           T_LW = 6'b100011, T_SW = 6'b101011, T_BEQ = 6'b000100,
                           T_J = 6'b000010;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [5:0]  op = '0, funct = '0;
    logic        mem_ready = 1'b0;
    logic        pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d;
    logic        alu_src_a, if_extend, reg_write, reg_dst, mem_to_reg, illegal_op;
    logic [1:0]  alu_src_b, pc_src;
    logic [4:0]  aluop;
    logic [31:0] retired;

    logic        p4_pcw, p4_pcc, p4_irw, p4_mr, p4_mw, p4_iod, p4_sa, p4_ext;
    logic        p4_rw, p4_dst, p4_m2r, p4_ill;
    logic [1:0]  p4_sb, p4_pcs;
    logic [4:0]  p4_alu;
    logic [3:0]  retired4;

    int total = 0, passed = 0;
    longint exp_ret = 0;

    always #5 clock = ~clock;

    mc_ctrl dut (
        .clock(clock), .reset(reset), .op(op), .funct(funct), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
        .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .if_extend(if_extend),
        .aluop(aluop), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .pc_src(pc_src), .illegal_op(illegal_op),
        .retired(retired)
    );

    mc_ctrl #(.CNT_W(4)) dut4 (
        .clock(clock), .reset(reset), .op(op), .funct(funct), .mem_ready(mem_ready),
        .pc_write(p4_pcw), .pc_write_cond(p4_pcc), .ir_write(p4_irw),
        .mem_read(p4_mr), .mem_write(p4_mw), .i_or_d(p4_iod),
        .alu_src_a(p4_sa), .alu_src_b(p4_sb), .if_extend(p4_ext),
        .aluop(p4_alu), .reg_write(p4_rw), .reg_dst(p4_dst),
        .mem_to_reg(p4_m2r), .pc_src(p4_pcs), .illegal_op(p4_ill),
        .retired(retired4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [20:0] out_vec();
        return {pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d,
                alu_src_a, alu_src_b, if_extend, aluop, reg_write, reg_dst,
                mem_to_reg, pc_src, illegal_op};
    endfunction

    function automatic bit supported(input logic [5:0] o);
        return o inside {T_R, T_ADDI, T_ORI, T_LW, T_SW, T_BEQ, T_J};
    endfunction

    function automatic logic [4:0] funct_alu(input logic [5:0] f);
        case (f)
            6'b100010: return 5'd1;
            6'b100100: return 5'd2;
            6'b100101: return 5'd3;
            6'b101010: return 5'd4;
            default:   return 5'd0;
        endcase
    endfunction

    function automatic bit funct_ok(input logic [5:0] f);
        return f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    endfunction

    // One instruction: memory responder inserts fw wait cycles on the fetch
    // and mw on the data access; aggregate behaviour compared at the end.
    // stop_after > 0 abandons the instruction after that many cycles.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                             input int fw, input int mw, input int stop_after);
        int n_cyc, fcnt, dcnt;
        int c_ir = 0, c_pcw = 0, c_pcw_j = 0, c_pcc = 0, c_rd = 0, c_wr = 0;
        int c_rw = 0, c_dacc = 0, c_ill = 0;
        logic [4:0] x_alu = 5'h1f;
        logic [1:0] x_srcb = 2'b11;
        logic x_ext = 1'b0, w_dst = 1'b0, w_m2r = 1'b0;
        bit is_lw = (o == T_LW), is_sw = (o == T_SW);
        bit wb = o inside {T_R, T_ADDI, T_ORI, T_LW};
        int base;
        fcnt = fw;
        dcnt = mw;
        case (o)
            T_R, T_ADDI, T_ORI, T_SW: base = 4;
            T_LW:                     base = 5;
            T_BEQ, T_J:               base = 3;
            default:                  base = 2;
        endcase
        n_cyc = base + fw + ((is_lw || is_sw) ? mw : 0);
        if (stop_after > 0) n_cyc = stop_after;
        for (int c = 0; c < n_cyc; c++) begin
            @(negedge clock);
            if (c == 0) begin
                op = o;
                funct = f;
                chk("fetch_req", {30'd0, mem_read, i_or_d}, 32'd2);
                chk("retired", retired, exp_ret[31:0]);
                chk("retired4", {28'd0, retired4}, {28'd0, exp_ret[3:0]});
            end
            if (mem_read || mem_write) begin
                if (!i_or_d) begin
                    mem_ready = (fcnt == 0);
                    if (fcnt > 0) fcnt--;
                end else begin
                    mem_ready = (dcnt == 0);
                    if (dcnt > 0) dcnt--;
                end
            end else begin
                mem_ready = 1'($urandom);
            end
            #1;
            c_ir  += int'(ir_write);
            c_pcw += int'(pc_write);
            c_pcc += int'(pc_write_cond && pc_src == 2'd1);
            c_rd  += int'(mem_read);
            c_wr  += int'(mem_write);
            c_ill += int'(illegal_op);
            c_dacc += int'((mem_read || mem_write) && i_or_d);
            if (pc_write && pc_src == 2'd2) c_pcw_j++;
            if (alu_src_a) begin
                x_alu = aluop;
                x_srcb = alu_src_b;
                x_ext = if_extend;
            end
            if (reg_write) begin
                c_rw++;
                w_dst = reg_dst;
                w_m2r = mem_to_reg;
            end
        end
        if (stop_after == 0) begin
            chk("ir_write_cycles", c_ir, 1);
            chk("pc_write_cycles", c_pcw, 1 + int'(o == T_J));
            chk("jump_pc_writes", c_pcw_j, int'(o == T_J));
            chk("branch_cond_writes", c_pcc, int'(o == T_BEQ));
            chk("mem_read_cycles", c_rd, fw + 1 + (is_lw ? mw + 1 : 0));
            chk("mem_write_cycles", c_wr, is_sw ? mw + 1 : 0);
            chk("data_access_cycles", c_dacc, (is_lw || is_sw) ? mw + 1 : 0);
            chk("reg_write_cycles", c_rw, int'(wb));
            chk("illegal_pulses", c_ill,
                int'(!supported(o) || (o == T_R && !funct_ok(f))));
            if (wb) begin
                chk("reg_dst", {31'd0, w_dst}, {31'd0, o == T_R});
                chk("mem_to_reg", {31'd0, w_m2r}, {31'd0, is_lw});
            end
            case (o)
                T_R:  chk("exec_alu", {x_ext, x_srcb, x_alu}, {1'b0, 2'd0, funct_alu(f)});
                T_BEQ: chk("exec_alu", {x_ext, x_srcb, x_alu}, {1'b0, 2'd0, 5'd1});
                T_ADDI, T_LW, T_SW:
                      chk("exec_alu", {x_ext, x_srcb, x_alu}, {1'b1, 2'd2, 5'd0});
                T_ORI: chk("exec_alu", {x_ext, x_srcb, x_alu}, {1'b0, 2'd2, 5'd3});
                default: chk("no_exec", {27'd0, x_alu}, 32'h1f);
            endcase
            if (supported(o)) exp_ret++;
        end
    endtask

    logic [5:0] op_pool [9] = '{T_R, T_ADDI, T_ORI, T_LW, T_SW, T_BEQ, T_J,
                                6'b111111, 6'b000001};
    logic [5:0] fn_pool [7] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                6'b101010, 6'b000111, 6'b111111};

    initial begin
        repeat (2) @(negedge clock);
        chk("reset_outputs", {11'd0, out_vec()}, 32'd0);
        chk("reset_retired", retired, 32'd0);
        #2 reset = 1'b1;
        #1 chk("first_fetch", {30'd0, mem_read, i_or_d}, 32'd2);

        run_instr(T_R, 6'b100000, 0, 0, 0);
        run_instr(T_LW, 6'b0, 0, 2, 0);
        run_instr(T_SW, 6'b0, 1, 1, 0);
        run_instr(T_BEQ, 6'b0, 0, 0, 0);
        run_instr(T_J, 6'b0, 2, 0, 0);
        run_instr(6'b111111, 6'b0, 0, 0, 0);
        run_instr(T_R, 6'b000111, 0, 0, 0);
        run_instr(T_ORI, 6'b0, 0, 0, 0);
        run_instr(T_ADDI, 6'b0, 0, 0, 0);

        for (int i = 0; i < 60; i++)
            run_instr(op_pool[$urandom_range(0, 8)], fn_pool[$urandom_range(0, 6)],
                      $urandom_range(0, 3), $urandom_range(0, 3), 0);

        // Abandon a store while it waits in MEM_WR, then reset mid-cycle.
        run_instr(T_SW, 6'b0, 0, 5, 5);
        chk("mem_write_before_reset", {31'd0, mem_write}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("async_reset_outputs", {11'd0, out_vec()}, 32'd0);
        chk("async_reset_retired", retired, 32'd0);
        chk("async_reset_retired4", {28'd0, retired4}, 32'd0);
        exp_ret = 0;
        @(negedge clock);
        #2 reset = 1'b1;
        #1 chk("fetch_after_reset", {30'd0, mem_read, i_or_d}, 32'd2);

        for (int i = 0; i < 17; i++) run_instr(T_J, 6'b0, 0, 0, 0);
        @(negedge clock);
        chk("final_retired", retired, 32'd17);
        chk("final_retired4_wrap", {28'd0, retired4}, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
